// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Issue stage in front of the ALU. It turns the main-decoder op class
//   (and, for R-type ops, the funct field) into a registered 4-bit ALU
//   control code. It also tracks how long a multi-cycle MUL keeps the ALU
//   occupied, so upstream is held off until the multiplier frees up.
//
// Parameters:
//   MUL_LAT        total ALU occupancy of a MUL in cycles (1..15)
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset
//   valid_i        upstream presents an op this cycle
//   ALUOp_i[2:0]   main-decoder op class
//   funct_i[5:0]   R-type funct field (only meaningful when ALUOp_i = 3'b010)
//   shamt_i[4:0]   instruction shift amount
//   stall_i        downstream stall, freezes all state
//   flush_i        squashes the issued op and any MUL occupancy
//   ready_o        combinational, op can be accepted this cycle
//   ctrl_o[3:0]    registered ALU control code
//   shamt_o[4:0]   registered shift amount (non-zero only for SRL)
//   valid_o        registered, ctrl_o/shamt_o carry a newly issued op
//   busy_o         registered, a MUL still occupies the ALU
//   unsupported_o  registered, issued op had an undefined funct
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [2:0] ALUOp_i,
    input  logic [5:0] funct_i,
    input  logic [4:0] shamt_i,
    input  logic       stall_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic [3:0] ctrl_o,
    output logic [4:0] shamt_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       unsupported_o
);

    // ALU control codes
    localparam logic [3:0] C_AND  = 4'd0;
    localparam logic [3:0] C_OR   = 4'd1;
    localparam logic [3:0] C_ADD  = 4'd2;
    localparam logic [3:0] C_SRL  = 4'd3;
    localparam logic [3:0] C_SRLV = 4'd4;
    localparam logic [3:0] C_LUI  = 4'd5;
    localparam logic [3:0] C_SUB  = 4'd6;
    localparam logic [3:0] C_SLT  = 4'd7;
    localparam logic [3:0] C_BGEZ = 4'd8;
    localparam logic [3:0] C_MUL  = 4'd9;
    localparam logic [3:0] C_NOR  = 4'd12;
    localparam logic [3:0] C_UNDF = 4'hF;

    // Counter value loaded when a MUL issues: the issue cycle itself is the
    // first of the MUL_LAT occupied cycles, so MUL_LAT-1 busy cycles remain.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MULBUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       unsup;
        logic       is_mul;
        logic       is_srl;
    } dec_t;

    // Op-class / funct decode into the ALU control code plus side flags.
    function automatic dec_t decode_op(input logic [2:0] aluop,
                                       input logic [5:0] funct);
        dec_t d;
        d = '{ctrl: C_ADD, unsup: 1'b0, is_mul: 1'b0, is_srl: 1'b0};
        unique case (aluop)
            3'b000: d.ctrl = C_ADD;
            3'b001: d.ctrl = C_SUB;
            3'b011: d.ctrl = C_SLT;
            3'b100: d.ctrl = C_LUI;
            3'b101: d.ctrl = C_OR;
            3'b110: d.ctrl = C_BGEZ;
            3'b111: d.ctrl = C_AND;
            3'b010: begin
                case (funct)
                    6'h20:   d.ctrl = C_ADD;
                    6'h22:   d.ctrl = C_SUB;
                    6'h24:   d.ctrl = C_AND;
                    6'h25:   d.ctrl = C_OR;
                    6'h27:   d.ctrl = C_NOR;
                    6'h2A:   d.ctrl = C_SLT;
                    6'h02: begin
                        d.ctrl   = C_SRL;
                        d.is_srl = 1'b1;
                    end
                    6'h06:   d.ctrl = C_SRLV;
                    6'h18: begin
                        d.ctrl   = C_MUL;
                        d.is_mul = 1'b1;
                    end
                    // Undefined funct issues as a single-cycle op with a
                    // marker code so the ALU side can trap it.
                    default: begin
                        d.ctrl  = C_UNDF;
                        d.unsup = 1'b1;
                    end
                endcase
            end
            default: d.ctrl = C_ADD;
        endcase
        return d;
    endfunction

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] ctrl_q,  ctrl_d;
    logic [4:0] shamt_q, shamt_d;
    logic       valid_q, valid_d;
    logic       busy_q,  busy_d;
    logic       unsup_q, unsup_d;

    dec_t       dec;
    logic       accept;

    assign dec     = decode_op(ALUOp_i, funct_i);
    assign ready_o = ~busy_q & ~stall_i;
    assign accept  = valid_i & ready_o;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ctrl_q  <= 4'd0;
            shamt_q <= 5'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            shamt_q <= shamt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            unsup_q <= unsup_d;
        end
    end

    // Next-state logic: flush > stall > accept > idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        shamt_d = shamt_q;
        unsup_d = unsup_q;
        valid_d = 1'b0;
        busy_d  = busy_q;

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            ctrl_d  = 4'd0;
            shamt_d = 5'd0;
            unsup_d = 1'b0;
            busy_d  = 1'b0;
        end else if (stall_i) begin
            // Everything freezes, including a pending valid_o pulse.
            valid_d = valid_q;
        end else begin
            if (accept) begin
                ctrl_d  = dec.ctrl;
                shamt_d = dec.is_srl ? shamt_i : 5'd0;
                unsup_d = dec.unsup;
                valid_d = 1'b1;
                // MUL_LAT=1 gives a zero load: the MUL behaves like any
                // single-cycle op and the FSM never leaves IDLE.
                if (dec.is_mul && (MUL_LOAD != 4'd0)) begin
                    cnt_d   = MUL_LOAD;
                    state_d = MULBUSY;
                end
            end else if (state_q == MULBUSY) begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            // busy follows the counter it will hold after this edge, so the
            // register reads exactly (cnt != 0).
            busy_d = (cnt_d != 4'd0);
        end
    end

    assign ctrl_o        = ctrl_q;
    assign shamt_o       = shamt_q;
    assign valid_o       = valid_q;
    assign busy_o        = busy_q;
    assign unsupported_o = unsup_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [2:0] ALUOp_i;
    logic [5:0] funct_i;
    logic [4:0] shamt_i;
    logic       stall_i;
    logic       flush_i;
    logic       ready_o;
    logic [3:0] ctrl_o;
    logic [4:0] shamt_o;
    logic       valid_o;
    logic       busy_o;
    logic       unsupported_o;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.MUL_LAT(3)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ALUOp_i       (ALUOp_i),
        .funct_i       (funct_i),
        .shamt_i       (shamt_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .ready_o       (ready_o),
        .ctrl_o        (ctrl_o),
        .shamt_o       (shamt_o),
        .valid_o       (valid_o),
        .busy_o        (busy_o),
        .unsupported_o (unsupported_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh);
        valid_i = v;
        ALUOp_i = op;
        funct_i = fn;
        shamt_i = sh;
    endtask

    logic [3:0] sweep_exp [8];

    initial begin
        sweep_exp = '{4'd2, 4'd6, 4'd2, 4'd7, 4'd5, 4'd1, 4'd8, 4'd0};

        // Reset overrides flush/stall/valid
        rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
        drive(1'b1, 3'b010, 6'h18, 5'd3);
        tick(); tick();
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        #1;
        check("rst_ctrl",  ctrl_o, 0);
        check("rst_shamt", shamt_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_unsup", unsupported_o, 0);
        check("rst_ready", ready_o, 1);

        // SRL carries shamt, then idle cycle holds the code
        drive(1'b1, 3'b010, 6'h02, 5'd7);
        tick();
        check("srl_ctrl",  ctrl_o, 3);
        check("srl_shamt", shamt_o, 7);
        check("srl_valid", valid_o, 1);
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        tick();
        check("idle_valid", valid_o, 0);
        check("idle_ctrl",  ctrl_o, 3);
        check("idle_shamt", shamt_o, 7);

        // SRLV does not forward shamt
        drive(1'b1, 3'b010, 6'h06, 5'd9);
        tick();
        check("srlv_ctrl",  ctrl_o, 4);
        check("srlv_shamt", shamt_o, 0);

        // Back-to-back single-cycle ops keep valid_o high
        drive(1'b1, 3'b000, 6'h00, 5'd0); tick();
        check("b2b_add", ctrl_o, 2);   check("b2b_v0", valid_o, 1);
        drive(1'b1, 3'b001, 6'h00, 5'd0); tick();
        check("b2b_sub", ctrl_o, 6);   check("b2b_v1", valid_o, 1);
        drive(1'b1, 3'b010, 6'h27, 5'd0); tick();
        check("b2b_nor", ctrl_o, 12);  check("b2b_v2", valid_o, 1);
        drive(1'b1, 3'b010, 6'h2A, 5'd0); tick();
        check("b2b_slt", ctrl_o, 7);   check("b2b_v3", valid_o, 1);
        drive(1'b1, 3'b010, 6'h22, 5'd0); tick();
        check("b2b_fsub", ctrl_o, 6);
        drive(1'b1, 3'b010, 6'h24, 5'd0); tick();
        check("b2b_fand", ctrl_o, 0);
        drive(1'b1, 3'b010, 6'h25, 5'd0); tick();
        check("b2b_for", ctrl_o, 1);

        // Unsupported funct, then cleared by the next valid op
        drive(1'b1, 3'b010, 6'h3F, 5'd4); tick();
        check("undf_ctrl",  ctrl_o, 4'hF);
        check("undf_unsup", unsupported_o, 1);
        check("undf_busy",  busy_o, 0);
        check("undf_ready", ready_o, 1);
        drive(1'b1, 3'b101, 6'h00, 5'd0); tick();
        check("undf_clr_ctrl",  ctrl_o, 1);
        check("undf_clr_unsup", unsupported_o, 0);

        // MUL occupancy with an ADD held upstream
        drive(1'b1, 3'b010, 6'h18, 5'd0); tick();
        check("mul_ctrl",  ctrl_o, 9);
        check("mul_valid", valid_o, 1);
        check("mul_busy0", busy_o, 1);
        check("mul_rdy0",  ready_o, 0);
        drive(1'b1, 3'b000, 6'h00, 5'd0); tick();
        check("mul_busy1",  busy_o, 1);
        check("mul_rdy1",   ready_o, 0);
        check("mul_valid1", valid_o, 0);
        check("mul_hold1",  ctrl_o, 9);
        tick();
        check("mul_busy2",  busy_o, 0);
        check("mul_rdy2",   ready_o, 1);
        check("mul_valid2", valid_o, 0);
        tick();
        check("mul_add_ctrl",  ctrl_o, 2);
        check("mul_add_valid", valid_o, 1);
        drive(1'b0, 3'b000, 6'h00, 5'd0); tick();

        // MUL with a 4-cycle stall while busy
        drive(1'b1, 3'b010, 6'h18, 5'd0); tick();
        check("stl_busy0", busy_o, 1);
        drive(1'b1, 3'b000, 6'h00, 5'd0);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stl_busy",  busy_o, 1);
            check("stl_valid", valid_o, 1);
            check("stl_ctrl",  ctrl_o, 9);
            check("stl_ready", ready_o, 0);
        end
        stall_i = 1'b0;
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        tick();
        check("stl_busy_u1",  busy_o, 1);
        check("stl_valid_u1", valid_o, 0);
        tick();
        check("stl_busy_u2",  busy_o, 0);
        check("stl_ready_u2", ready_o, 1);

        // Flush during MULBUSY under stall, with valid_i asserted
        drive(1'b1, 3'b010, 6'h18, 5'd0); tick();
        check("fl_busy0", busy_o, 1);
        drive(1'b1, 3'b111, 6'h00, 5'd0);
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        check("fl_busy",  busy_o, 0);
        check("fl_valid", valid_o, 0);
        check("fl_ctrl",  ctrl_o, 0);
        check("fl_shamt", shamt_o, 0);
        check("fl_unsup", unsupported_o, 0);
        stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        #1;
        check("fl_ready", ready_o, 1);

        // Reset mid-MUL
        drive(1'b1, 3'b010, 6'h18, 5'd0); tick();
        check("rm_busy0", busy_o, 1);
        rst_i = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
        tick();
        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        #1;
        check("rm_ctrl",  ctrl_o, 0);
        check("rm_valid", valid_o, 0);
        check("rm_busy",  busy_o, 0);
        check("rm_ready", ready_o, 1);

        // Sweep all op classes; shamt must not pass for non-SRL
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 6'h20, 5'd31);
            tick();
            check($sformatf("sweep_ctrl%0d", i),  ctrl_o, sweep_exp[i]);
            check($sformatf("sweep_valid%0d", i), valid_o, 1);
            check($sformatf("sweep_shamt%0d", i), shamt_o, 0);
        end
        drive(1'b0, 3'b000, 6'h00, 5'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
